// File: rtl/uart_stim_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_stim_tx
// Purpose  : 8N1 UART transmitter fed by a small byte FIFO. Drives a UART
//            receive pin with scripted byte streams (bench or FPGA host).
// Ports    : clk          - single rising-edge clock
//            reset        - synchronous active-high reset
//            baud_div_i   - clock cycles per bit (0 treated as 1), latched
//                           per frame
//            wr_valid_i   - byte push request
//            wr_data_i    - byte to push
//            wr_ready_o   - FIFO not full (from registered count)
//            uart_txd_o   - serial line, idles high
//            busy_o       - frame on the line or bytes queued
//            fifo_count_o - bytes currently queued
// Revision : 1.0 - initial release
// ============================================================================
module uart_stim_tx #(
    parameter int FIFO_DEPTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [15:0]                 baud_div_i,
    input  logic                        wr_valid_i,
    input  logic [7:0]                  wr_data_i,
    output logic                        wr_ready_o,
    output logic                        uart_txd_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    // FIFO storage and bookkeeping
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Transmitter state
    logic [1:0]  r_state;
    logic [7:0]  r_shift;
    logic [15:0] r_div;
    logic [15:0] r_timer;
    logic [2:0]  r_bit_idx;
    logic [16:0] r_stop_cnt;

    logic        w_push;
    logic        w_pop;
    logic        w_have_data;
    logic [15:0] w_div_eff;
    logic        w_bit_end;
    logic [16:0] w_stop_len;
    logic        w_stop_end;

    assign w_have_data = (r_count != '0);
    assign wr_ready_o  = (r_count != c_FULL);
    assign w_push      = wr_valid_i & wr_ready_o;
    assign w_div_eff   = (baud_div_i == 16'd0) ? 16'd1 : baud_div_i;
    assign w_bit_end   = (r_timer == (r_div - 16'd1));

    // Stop period is one or two bit times; 17 bits hold 2 x 65535.
    assign w_stop_len  = (STOP_BITS == 2) ? {r_div, 1'b0} : {1'b0, r_div};
    assign w_stop_end  = (r_stop_cnt == (w_stop_len - 17'd1));

    // A new frame is loaded either from idle or straight out of the last
    // stop cycle, which is what gives back-to-back frames with no gap.
    assign w_pop = w_have_data &
                   ((r_state == c_S_IDLE) || ((r_state == c_S_STOP) && w_stop_end));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_S_IDLE;
            r_shift    <= 8'd0;
            r_div      <= 16'd1;
            r_timer    <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_stop_cnt <= 17'd0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_div   <= w_div_eff;
                        r_timer <= 16'd0;
                        r_state <= c_S_START;
                    end
                end
                c_S_START: begin
                    if (w_bit_end) begin
                        r_timer   <= 16'd0;
                        r_bit_idx <= 3'd0;
                        r_state   <= c_S_DATA;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                c_S_DATA: begin
                    if (w_bit_end) begin
                        r_timer <= 16'd0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_stop_cnt <= 17'd0;
                            r_state    <= c_S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                default: begin
                    if (w_stop_end) begin
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_div   <= w_div_eff;
                            r_timer <= 16'd0;
                            r_state <= c_S_START;
                        end else begin
                            r_state <= c_S_IDLE;
                        end
                    end else begin
                        r_stop_cnt <= r_stop_cnt + 17'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        uart_txd_o = 1'b1;
        case (r_state)
            c_S_START: uart_txd_o = 1'b0;
            c_S_DATA:  uart_txd_o = r_shift[0];
            default:   uart_txd_o = 1'b1;
        endcase
    end

    assign busy_o       = (r_state != c_S_IDLE) | w_have_data;
    assign fifo_count_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_stim_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_stim_tx
// Purpose  : Directed self-checking bench for uart_stim_tx. One instance with
//            one stop bit carries most cases; a second with two stop bits
//            covers the long stop period.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_stim_tx;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] baud_div;
    logic        wr_valid;
    logic        wr_valid2;
    logic [7:0]  wr_data;
    logic        wr_ready, txd, busy;
    logic [3:0]  count;
    logic        wr_ready2, txd2, busy2;
    logic [3:0]  count2;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] rb;
    logic       rbad;
    logic       flag;
    logic [7:0] exp_pp [4] = '{8'h22, 8'h33, 8'h44, 8'h55};

    always #5 clk = ~clk;

    uart_stim_tx #(.FIFO_DEPTH(8), .STOP_BITS(1)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .baud_div_i   (baud_div),
        .wr_valid_i   (wr_valid),
        .wr_data_i    (wr_data),
        .wr_ready_o   (wr_ready),
        .uart_txd_o   (txd),
        .busy_o       (busy),
        .fifo_count_o (count)
    );

    uart_stim_tx #(.FIFO_DEPTH(8), .STOP_BITS(2)) u_dut2 (
        .clk          (clk),
        .reset        (reset),
        .baud_div_i   (baud_div),
        .wr_valid_i   (wr_valid2),
        .wr_data_i    (wr_data),
        .wr_ready_o   (wr_ready2),
        .uart_txd_o   (txd2),
        .busy_o       (busy2),
        .fifo_count_o (count2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic line(input bit sel);
        return sel ? txd2 : txd;
    endfunction

    function automatic logic bsy(input bit sel);
        return sel ? busy2 : busy;
    endfunction

    task automatic push_one(input logic [7:0] b);
        wr_data  = b;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    // Called on the first cycle of a start bit; consumes exactly one frame.
    task automatic rx_byte(input int d, input int nstop, input bit sel,
                           output logic [7:0] data, output logic bad);
        logic v;
        data = 8'd0;
        bad  = 1'b0;
        for (int b = 0; b < 9; b++) begin
            v = line(sel);
            for (int c = 0; c < d; c++) begin
                if (line(sel) !== v || bsy(sel) !== 1'b1) bad = 1'b1;
                tick();
            end
            if (b == 0) begin
                if (v !== 1'b0) bad = 1'b1;
            end else begin
                data = {v, data[7:1]};
            end
        end
        for (int c = 0; c < nstop * d; c++) begin
            if (line(sel) !== 1'b1 || bsy(sel) !== 1'b1) bad = 1'b1;
            tick();
        end
    endtask

    initial begin
        reset     = 1'b1;
        baud_div  = 16'd4;
        wr_valid  = 1'b0;
        wr_valid2 = 1'b0;
        wr_data   = 8'd0;
        tick();
        tick();
        check_eq("rst_txd",   32'(txd),      1);
        check_eq("rst_ready", 32'(wr_ready), 1);
        check_eq("rst_busy",  32'(busy),     0);
        check_eq("rst_count", 32'(count),    0);
        reset = 1'b0;
        tick();

        // Single byte, D=4
        baud_div = 16'd4;
        push_one(8'h55);
        check_eq("single_cnt_push", 32'(count), 1);
        check_eq("single_line_k",   32'(txd),   1);
        tick();
        check_eq("single_start_low", 32'(txd),   0);
        check_eq("single_cnt_pop",   32'(count), 0);
        rx_byte(4, 1, 1'b0, rb, rbad);
        check_eq("single_data", 32'(rb),   32'h55);
        check_eq("single_bits", 32'(rbad), 0);
        check_eq("single_busy_end", 32'(busy), 0);

        // Burst of 11 bytes with wr_valid held, D=2
        baud_div = 16'd2;
        fork
            begin
                int guard;
                for (int i = 0; i < 11; i++) begin
                    guard    = 0;
                    wr_data  = 8'(i);
                    wr_valid = 1'b1;
                    while (!wr_ready && guard < 100) begin
                        tick();
                        guard++;
                    end
                    tick();
                end
                wr_valid = 1'b0;
            end
            begin
                logic [7:0] b8;
                logic       bb;
                int         t;
                t = 0;
                while (txd !== 1'b0 && t < 50) begin
                    tick();
                    t++;
                end
                check_eq("burst_start", 32'(txd), 0);
                for (int i = 0; i < 11; i++) begin
                    rx_byte(2, 1, 1'b0, b8, bb);
                    check_eq("burst_data", 32'(b8), i);
                    check_eq("burst_bits", 32'(bb), 0);
                    if (i < 10) check_eq("burst_gap", 32'(txd), 0);
                end
                check_eq("burst_busy_end", 32'(busy), 0);
            end
            begin
                int   maxc;
                logic viol;
                maxc = 0;
                viol = 1'b0;
                for (int c = 0; c < 230; c++) begin
                    if (int'(count) > maxc) maxc = int'(count);
                    if ((count == 4'd8) == wr_ready) viol = 1'b1;
                    tick();
                end
                check_eq("burst_max_cnt",   32'(maxc), 8);
                check_eq("burst_ready_full", 32'(viol), 0);
            end
        join

        // Simultaneous push and pop at count 3, D=2
        push_one(8'h11);
        tick();
        check_eq("pp_start", 32'(txd), 0);
        wr_valid = 1'b1;
        wr_data  = 8'h22; tick();
        wr_data  = 8'h33; tick();
        wr_data  = 8'h44; tick();
        wr_valid = 1'b0;
        check_eq("pp_cnt_pre", 32'(count), 3);
        repeat (16) tick();
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        tick();
        wr_valid = 1'b0;
        check_eq("pp_cnt_same", 32'(count), 3);
        check_eq("pp_next_start", 32'(txd), 0);
        for (int i = 0; i < 4; i++) begin
            rx_byte(2, 1, 1'b0, rb, rbad);
            check_eq("pp_data", 32'(rb), 32'(exp_pp[i]));
            check_eq("pp_bits", 32'(rbad), 0);
            if (i < 3) check_eq("pp_gap", 32'(txd), 0);
        end
        check_eq("pp_busy_end", 32'(busy), 0);

        // Full FIFO: push refused in the cycle of a pop, D=2
        wr_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wr_data = 8'h80 + 8'(i);
            tick();
        end
        wr_data = 8'hEE;
        check_eq("full_cnt",   32'(count),    8);
        check_eq("full_ready", 32'(wr_ready), 0);
        repeat (12) tick();
        check_eq("full_cnt_hold", 32'(count), 8);
        tick();
        wr_valid = 1'b0;
        check_eq("full_pop_cnt",   32'(count),    7);
        check_eq("full_pop_ready", 32'(wr_ready), 1);
        check_eq("full_pop_start", 32'(txd),      0);
        for (int i = 1; i < 9; i++) begin
            rx_byte(2, 1, 1'b0, rb, rbad);
            check_eq("full_data", 32'(rb), 32'h80 + i);
            check_eq("full_bits", 32'(rbad), 0);
        end
        check_eq("full_busy_end", 32'(busy), 0);

        // D=0 acts as D=1
        baud_div = 16'd0;
        push_one(8'hA5);
        tick();
        check_eq("d0_start", 32'(txd), 0);
        rx_byte(1, 1, 1'b0, rb, rbad);
        check_eq("d0_data", 32'(rb),   32'hA5);
        check_eq("d0_bits", 32'(rbad), 0);
        check_eq("d0_busy_end", 32'(busy), 0);

        // Two stop bits at D=3 on the second instance
        baud_div  = 16'd3;
        wr_data   = 8'h3C;
        wr_valid2 = 1'b1;
        tick();
        wr_valid2 = 1'b0;
        tick();
        check_eq("stop2_start", 32'(txd2),      0);
        check_eq("stop2_cnt",   32'(count2),    0);
        check_eq("stop2_ready", 32'(wr_ready2), 1);
        rx_byte(3, 2, 1'b1, rb, rbad);
        check_eq("stop2_data", 32'(rb),   32'h3C);
        check_eq("stop2_bits", 32'(rbad), 0);
        check_eq("stop2_busy_end", 32'(busy2), 0);

        // Divisor change mid-frame: 3 for current frame, 5 for next
        baud_div = 16'd3;
        wr_valid = 1'b1;
        wr_data  = 8'h0F; tick();
        wr_data  = 8'hF0; tick();
        wr_valid = 1'b0;
        baud_div = 16'd5;
        check_eq("div_start", 32'(txd), 0);
        rx_byte(3, 1, 1'b0, rb, rbad);
        check_eq("div_data0", 32'(rb),   32'h0F);
        check_eq("div_bits0", 32'(rbad), 0);
        check_eq("div_gap",   32'(txd),  0);
        rx_byte(5, 1, 1'b0, rb, rbad);
        check_eq("div_data1", 32'(rb),   32'hF0);
        check_eq("div_bits1", 32'(rbad), 0);
        check_eq("div_busy_end", 32'(busy), 0);

        // Reset during data bit 4 with 3 bytes queued, D=2
        baud_div = 16'd2;
        wr_valid = 1'b1;
        wr_data  = 8'h00; tick();
        wr_data  = 8'h01; tick();
        wr_data  = 8'h02; tick();
        wr_data  = 8'h03; tick();
        wr_valid = 1'b0;
        repeat (8) tick();
        check_eq("rstmid_cnt_pre",  32'(count), 3);
        check_eq("rstmid_line_pre", 32'(txd),   0);
        reset = 1'b1;
        tick();
        check_eq("rstmid_txd",   32'(txd),      1);
        check_eq("rstmid_cnt",   32'(count),    0);
        check_eq("rstmid_busy",  32'(busy),     0);
        check_eq("rstmid_ready", 32'(wr_ready), 1);
        reset = 1'b0;
        flag  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (txd !== 1'b1 || busy !== 1'b0) flag = 1'b1;
        end
        check_eq("rstmid_quiet", 32'(flag), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_stim_tx.md
# uart_stim_tx

Synthesizable 8N1 UART transmitter with a small input FIFO. The bench instantiates it to drive the SoC's `uart_rxd_i` pin, so firmware UART-receive paths can be exercised with scripted byte streams. It is the counterpart of the bench's UART-TX log capture. Because it is RTL rather than a behavioural task, it can also be reused on FPGA as a host-side stimulus source.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: number of byte entries; must be a power of two, ≥2.
- `STOP_BITS`, 1: stop bits per frame; legal values are 1 and 2.

Ports:
- `clk`  in  1: single clock; all logic updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `baud_div_i`  in  16: clock cycles per UART bit (D); a value of 0 is treated as 1.
- `wr_valid_i`  in  1: byte push request.
- `wr_data_i`  in  8: byte to transmit.
- `wr_ready_o`  out  1: FIFO can accept a byte; a push occurs when `wr_valid_i & wr_ready_o`.
- `uart_txd_o`  out  1: serial line; idles high.
- `busy_o`  out  1: high while a frame is on the line or the FIFO is non-empty.
- `fifo_count_o`  out  $clog2(FIFO_DEPTH)+1: number of bytes currently queued.

## Operation
- FIFO: circular buffer with wrapping read and write pointers plus an occupancy count.
  - `wr_ready_o = (count != FIFO_DEPTH)`, taken from registered count only. When the FIFO is full, a push is refused even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave the count unchanged and both pointers advance.
  - A push is ignored when `wr_ready_o` = 0. The caller must hold `wr_data_i` until it is accepted.
- FSM states:
  - IDLE: `uart_txd_o` = 1. If count > 0, pop the head byte into the shift register, latch `baud_div_i` into the divisor register, and go to START.
  - START: drive 0 for D cycles, then go to DATA with bit index 0.
  - DATA: drive `shift[0]` for D cycles, then shift right. After bit index 7, go to STOP.
  - STOP: drive 1 for `STOP_BITS`×D cycles. At the end, if count > 0, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Bit timer: counts 0..D−1 and resets at each bit boundary. The divisor is latched per frame, so changing `baud_div_i` mid-frame has no effect until the next frame.
- Bit order: LSB first. A frame is 1 start bit, 8 data bits, then `STOP_BITS` stop bits.
- `busy_o = (state != IDLE) | (count != 0)`.

## Timing
- Reset values: `uart_txd_o` = 1, `wr_ready_o` = 1, `busy_o` = 0, `fifo_count_o` = 0. Internal state: FSM in IDLE, pointers and timer at 0.
- Reset asserted mid-frame: on the next edge the line returns high, the FIFO is emptied, and queued bytes are discarded. No partial frame resumes after reset deasserts.
- Latency from an empty, idle block: a byte pushed at edge k makes `uart_txd_o` fall after edge k+1. `fifo_count_o` reads 1 after edge k and 0 after edge k+1.
- Each bit is held for exactly D clock cycles.
- Frame length is (9+`STOP_BITS`)×D cycles.
- Back-to-back frames: the start bit of frame n+1 begins on the cycle immediately after the last stop cycle of frame n.
- `busy_o` falls on the edge where the FSM enters IDLE with count = 0.
- `wr_ready_o` rises the cycle after a pop from a full FIFO.
- Counter widths:
  - Bit timer: 16 bits.
  - Stop counter: sized for 2×65535 cycles.
  - No overflow is possible at D = 65535 with `STOP_BITS` = 2.

## Test plan
- Single byte: D=4, `STOP_BITS`=1, push 0x55 at edge k.
  - The line samples, one per 4 cycles, are 0,1,0,1,0,1,0,1,0,1.
  - Low begins after edge k+1.
  - `busy_o` falls 40 cycles after the start bit begins.
- Burst/full: D=2, `FIFO_DEPTH`=8, hold `wr_valid_i` high with bytes 0x00..0x0A.
  - `wr_ready_o` drops when count reaches 8 and reasserts the cycle after each pop.
  - All 11 bytes are decoded in order, with no idle gap between frames (each frame exactly 20 cycles).
- Simultaneous push/pop at count=3: `fifo_count_o` stays 3 and the data order is preserved.
- Full plus pop: count=8, push in the same cycle as a pop. The push is refused (`wr_ready_o` = 0), and the count goes to 7.
- Divisor edges:
  - D=0 behaves as D=1: a 0xA5 frame lasts 10 cycles.
  - With `STOP_BITS`=2 and D=3, the stop bits last 6 cycles.
  - Changing `baud_div_i` from 3 to 5 mid-frame keeps 3 for the current frame and uses 5 for the next one.
- Reset mid-frame: with 3 bytes queued, assert `reset` during DATA bit 4.
  - After the next edge: `uart_txd_o` = 1, count = 0, `busy_o` = 0.
  - After `reset` deasserts, the line stays high with no frame emitted.
